// File: rtl/qk_score_row_pkg.sv
// -----------------------------------------------------------------------------
// qk_score_row_pkg
// Shared definitions for the Q*K^T score-row block:
//   - state_e : FSM state encodings (IDLE, ACCUM, OUTPUT)
//   - clog2   : ceiling log2, used to size the beat counter and the
//               dot-product accumulator
// -----------------------------------------------------------------------------
package qk_score_row_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0 so a single-element sum needs no extra bits.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 32'sd0;
    rem = value - 32'sd1;
    while (rem > 32'sd0) begin
      res = res + 32'sd1;
      rem = rem >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/qk_dot.sv
// -----------------------------------------------------------------------------
// qk_dot
// Combinational dot product of one Q vector and one K vector, followed by
// quantisation to the Softmax input format.
// Ports:
//   q_vec_i  [W*L-1:0]  Q vector, element i at [W*(i+1)-1:W*i]
//   k_vec_i  [W*L-1:0]  K vector, same packing
//   score_o  [OW-1:0]   quantised score (truncated, saturated to all-ones)
// -----------------------------------------------------------------------------
module qk_dot
  import qk_score_row_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int DATA_LENGTH       = 4
) (
  input  logic [INPUT_DATA_WIDTH*DATA_LENGTH-1:0] q_vec_i,
  input  logic [INPUT_DATA_WIDTH*DATA_LENGTH-1:0] k_vec_i,
  output logic [OUTPUT_DATA_WIDTH-1:0]            score_o
);

  localparam int W      = INPUT_DATA_WIDTH;
  localparam int OW     = OUTPUT_DATA_WIDTH;
  localparam int L      = DATA_LENGTH;
  localparam int PROD_W = 2 * W;
  // Sum of L products can never overflow this width.
  localparam int SUM_W  = PROD_W + clog2(L);
  // Products carry W fractional bits; keep only OW/2 of them.
  localparam int DROP   = W - (OW / 2);
  localparam int SH_W   = SUM_W - DROP;
  localparam int EXT_W  = (SH_W > OW) ? SH_W : OW;

  logic [PROD_W-1:0] prod_s [L];
  logic [SUM_W-1:0]  sum_s;
  logic [SH_W-1:0]   trunc_s;
  logic [EXT_W-1:0]  ext_s;
  logic [OW-1:0]     score_s;

  for (genvar i = 0; i < L; i++) begin : g_mul
    assign prod_s[i] = PROD_W'(q_vec_i[i*W +: W]) * PROD_W'(k_vec_i[i*W +: W]);
  end

  // Adder tree over all element products.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < L; i++) begin
      sum_s = sum_s + SUM_W'(prod_s[i]);
    end
  end

  // Truncation toward zero is simply discarding the low fractional bits.
  assign trunc_s = sum_s[SUM_W-1:DROP];
  assign ext_s   = EXT_W'(trunc_s);

  // Saturate when the integer part does not fit the output format.
  always_comb begin
    if (ext_s > EXT_W'({OW{1'b1}})) begin
      score_s = '1;
    end else begin
      score_s = ext_s[OW-1:0];
    end
  end

  assign score_o = score_s;

endmodule

// File: rtl/qk_score_row.sv
// -----------------------------------------------------------------------------
// qk_score_row
// Computes one row of S = Q*K^T: latches a Q vector, then consumes
// DATA_LENGTH K vectors (one score per beat) and presents the packed score
// row on a valid/ready output until it is taken.
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   q_valid/q_ready    Q vector handshake, q_row carries the vector
//   k_valid/k_ready    K vector handshake, k_row carries the vector
//   s_valid/s_ready    score-row handshake, s_row carries scores (slot j from
//                      K beat j, LSB first)
// -----------------------------------------------------------------------------
module qk_score_row
  import qk_score_row_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int DATA_LENGTH       = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     q_valid,
  output logic                                     q_ready,
  input  logic [INPUT_DATA_WIDTH*DATA_LENGTH-1:0]  q_row,
  input  logic                                     k_valid,
  output logic                                     k_ready,
  input  logic [INPUT_DATA_WIDTH*DATA_LENGTH-1:0]  k_row,
  output logic                                     s_valid,
  input  logic                                     s_ready,
  output logic [OUTPUT_DATA_WIDTH*DATA_LENGTH-1:0] s_row
);

  localparam int W     = INPUT_DATA_WIDTH;
  localparam int OW    = OUTPUT_DATA_WIDTH;
  localparam int L     = DATA_LENGTH;
  localparam int CNT_W = clog2(L + 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W*L-1:0]   q_reg_q;
  logic [OW-1:0]    slot_q [L];
  logic             q_ready_q;
  logic             k_ready_q;
  logic             s_valid_q;
  logic [OW-1:0]    score_d;
  logic             last_beat_s;

  qk_dot #(
    .INPUT_DATA_WIDTH  (W),
    .OUTPUT_DATA_WIDTH (OW),
    .DATA_LENGTH       (L)
  ) u_dot (
    .q_vec_i (q_reg_q),
    .k_vec_i (k_row),
    .score_o (score_d)
  );

  assign last_beat_s = (cnt_q == CNT_W'(L - 1));

  // Row FSM: handshake outputs are registered alongside the state so they
  // change on the same edge as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      q_reg_q   <= '0;
      q_ready_q <= 1'b1;
      k_ready_q <= 1'b0;
      s_valid_q <= 1'b0;
      for (int j = 0; j < L; j++) begin
        slot_q[j] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (q_valid && q_ready_q) begin
            q_reg_q   <= q_row;
            cnt_q     <= '0;
            state_q   <= ST_ACCUM;
            q_ready_q <= 1'b0;
            k_ready_q <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (k_valid && k_ready_q) begin
            for (int j = 0; j < L; j++) begin
              if (cnt_q == CNT_W'(j)) begin
                slot_q[j] <= score_d;
              end
            end
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat_s) begin
              state_q   <= ST_OUTPUT;
              k_ready_q <= 1'b0;
              s_valid_q <= 1'b1;
            end
          end
        end
        ST_OUTPUT: begin
          // Slots are left as-is; they are overwritten by the next row.
          if (s_valid_q && s_ready) begin
            state_q   <= ST_IDLE;
            s_valid_q <= 1'b0;
            q_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          q_ready_q <= 1'b1;
          k_ready_q <= 1'b0;
          s_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign q_ready = q_ready_q;
  assign k_ready = k_ready_q;
  assign s_valid = s_valid_q;

  for (genvar j = 0; j < L; j++) begin : g_pack
    assign s_row[j*OW +: OW] = slot_q[j];
  end

endmodule
